// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with PC, imem handshake, decode hold and mispredict redirect.
// Define FETCH_RVFI_EN to drive IF_pc_rdata with the delivered PC; otherwise it is tied to 0.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall_decode,
    input  logic        mispredict,
    input  logic [31:0] redirect_target,
    output logic [31:0] IF_instr_data,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_pc_rdata,
    output logic        stall_fetch
);
    typedef enum logic [1:0] {FETCH, HOLD, FLUSH} state_t;
    state_t      state;
    logic [31:0] pc, hold_instr, hold_pc, pend_target, target;
    logic        deliver;
    assign target       = redirect_target & 32'hFFFF_FFFC;
    assign deliver      = !rst && !mispredict && !stall_decode &&
                          ((state == FETCH && imem_resp) || state == HOLD);
    assign imem_address = pc;
    assign imem_read    = !rst && state != HOLD;
    assign stall_fetch  = !deliver;
    // HOLD keeps presenting the captured word even while decode is stalled
    assign IF_instr_data = rst ? '0 : state == HOLD ? hold_instr : deliver ? imem_rdata : '0;
    assign IF_pc         = rst ? '0 : state == HOLD ? hold_pc : deliver ? pc : '0;
`ifdef FETCH_RVFI_EN
    assign IF_pc_rdata = deliver ? IF_pc : '0;
`else
    assign IF_pc_rdata = '0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC & 32'hFFFF_FFFC;
            state       <= FETCH;
            hold_instr  <= '0;
            hold_pc     <= '0;
            pend_target <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mispredict) begin
                        if (imem_resp) pc <= target;
                        else begin
                            pend_target <= target;
                            state       <= FLUSH;
                        end
                    end else if (imem_resp) begin
                        pc <= pc + 32'd4;
                        if (stall_decode) begin
                            hold_instr <= imem_rdata;
                            hold_pc    <= pc;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (mispredict) begin
                        pc         <= target;
                        hold_instr <= '0;
                        hold_pc    <= '0;
                        state      <= FETCH;
                    end else if (!stall_decode) state <= FETCH;
                end
                FLUSH: begin
                    // the stale response must drain before the new target is requested
                    if (mispredict) pend_target <= target;
                    if (imem_resp) begin
                        pc    <= mispredict ? target : pend_target;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a latency-configurable memory model and a delivery scoreboard.
module tb_fetch_stage;
    logic        clk = 0, rst = 1;
    logic [31:0] imem_address, imem_rdata = 0, redirect_target = 0;
    logic        imem_read, imem_resp = 0, stall_decode = 0, mispredict = 0, stall_fetch;
    logic [31:0] IF_instr_data, IF_pc, IF_pc_rdata;
    int          tests = 0, fails = 0;
    int          lat = 1, cnt = 0;
    logic        prev_read = 0, prev_resp = 0, spur = 0;
    logic [31:0] exp_q[$];

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_address(imem_address), .imem_read(imem_read),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp), .stall_decode(stall_decode),
        .mispredict(mispredict), .redirect_target(redirect_target),
        .IF_instr_data(IF_instr_data), .IF_pc(IF_pc), .IF_pc_rdata(IF_pc_rdata),
        .stall_fetch(stall_fetch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    // memory answers after lat cycles of a held request; instruction word is ~address
    task automatic cycle(input logic r, input logic sd, input logic mp, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        cnt = (prev_resp || !prev_read) ? 0 : cnt + 1;
        rst = r;
        stall_decode = sd;
        mispredict = mp;
        redirect_target = tgt;
        #0;
        imem_resp = (imem_read && cnt >= lat - 1) || spur;
        imem_rdata = imem_resp ? ~imem_address : 32'hDEAD_BEEF;
        prev_read = imem_read;
        prev_resp = imem_resp;
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && !stall_fetch) begin
            if (exp_q.size() == 0) chk("unexpected_delivery_pc", IF_pc, 32'hXXXX_XXXX);
            else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("deliver_pc", IF_pc, e);
                chk("deliver_instr", IF_instr_data, ~e);
`ifdef FETCH_RVFI_EN
                chk("deliver_rvfi", IF_pc_rdata, e);
`else
                chk("deliver_rvfi", IF_pc_rdata, 32'h0);
`endif
            end
        end
    end

    initial begin
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("rst_read", imem_read, 0);
        chk("rst_stall", stall_fetch, 1);
        chk("rst_pc", IF_pc, 0);
        chk("rst_instr", IF_instr_data, 0);
        chk("rst_addr", imem_address, 32'h4000_0000);
        // single-cycle memory: back-to-back deliveries
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h4000_0000 + 32'(4 * i));
            cycle(0, 0, 0, 0);
            chk("seq_addr", imem_address, 32'h4000_0000 + 32'(4 * i));
            chk("seq_stall", stall_fetch, 0);
        end
        // 3-cycle latency
        lat = 3;
        cycle(0, 0, 0, 0);
        chk("lat_stall1", stall_fetch, 1);
        chk("lat_addr1", imem_address, 32'h4000_000C);
        chk("lat_bubble", IF_instr_data, 0);
        cycle(0, 0, 0, 0);
        chk("lat_stall2", stall_fetch, 1);
        chk("lat_addr2", imem_address, 32'h4000_000C);
        exp_q.push_back(32'h4000_000C);
        cycle(0, 0, 0, 0);
        chk("lat_deliver", stall_fetch, 0);
        // decode stall across a response -> HOLD
        lat = 1;
        exp_q.push_back(32'h4000_0010);
        cycle(0, 1, 0, 0);
        chk("hold_enter_stall", stall_fetch, 1);
        for (int i = 0; i < 3; i++) begin
            spur = (i == 1);
            cycle(0, 1, 0, 0);
            chk("hold_read", imem_read, 0);
            chk("hold_stall", stall_fetch, 1);
            chk("hold_pc", IF_pc, 32'h4000_0010);
        end
        spur = 0;
        cycle(0, 0, 0, 0);
        chk("hold_release", stall_fetch, 0);
        exp_q.push_back(32'h4000_0014);
        cycle(0, 0, 0, 0);
        chk("after_hold_addr", imem_address, 32'h4000_0014);
        exp_q.push_back(32'h4000_0018);
        cycle(0, 0, 0, 0);
        exp_q.push_back(32'h4000_001C);
        cycle(0, 0, 0, 0);
        // mispredict with a request outstanding
        lat = 3;
        cycle(0, 0, 0, 0);
        chk("mp_out_addr", imem_address, 32'h4000_0020);
        cycle(0, 0, 1, 32'h4000_0100);
        chk("mp_out_stall", stall_fetch, 1);
        cycle(0, 0, 0, 0);
        chk("flush_addr", imem_address, 32'h4000_0020);
        chk("flush_read", imem_read, 1);
        chk("flush_stall", stall_fetch, 1);
        chk("flush_bubble_pc", IF_pc, 0);
        lat = 1;
        exp_q.push_back(32'h4000_0100);
        cycle(0, 0, 0, 0);
        chk("mp_target_addr", imem_address, 32'h4000_0100);
        // mispredict together with a response; target low bits ignored
        cycle(0, 0, 1, 32'h4000_0203);
        chk("mp_resp_stall", stall_fetch, 1);
        chk("mp_resp_pc", IF_pc, 0);
        chk("mp_resp_instr", IF_instr_data, 0);
        chk("mp_resp_rvfi", IF_pc_rdata, 0);
        lat = 3;
        cycle(0, 0, 1, 32'h4000_0300);
        chk("mp_resp_next", imem_address, 32'h4000_0200);
        cycle(0, 0, 1, 32'h4000_0400);
        chk("flush_mp_stall", stall_fetch, 1);
        cycle(0, 0, 0, 0);
        lat = 1;
        exp_q.push_back(32'h4000_0400);
        cycle(0, 0, 0, 0);
        chk("later_target", imem_address, 32'h4000_0400);
        // mispredict in FLUSH coinciding with the drain response
        lat = 2;
        cycle(0, 0, 1, 32'h4000_0500);
        cycle(0, 0, 1, 32'h4000_0600);
        chk("flush_resp_mp_stall", stall_fetch, 1);
        lat = 1;
        cycle(0, 1, 0, 0);
        chk("flush_resp_mp_addr", imem_address, 32'h4000_0600);
        // mispredict in HOLD drops the held word
        cycle(0, 1, 1, 32'h4000_0700);
        chk("hold_mp_stall", stall_fetch, 1);
        exp_q.push_back(32'h4000_0700);
        cycle(0, 0, 0, 0);
        chk("hold_mp_addr", imem_address, 32'h4000_0700);
        // PC wrap
        cycle(0, 0, 1, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        chk("wrap_top", imem_address, 32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        cycle(0, 0, 0, 0);
        chk("wrap_zero", imem_address, 32'h0000_0000);
        // reset in the middle of HOLD
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        chk("midrst_read", imem_read, 0);
        chk("midrst_stall", stall_fetch, 1);
        chk("midrst_pc", IF_pc, 0);
        chk("midrst_instr", IF_instr_data, 0);
        exp_q.push_back(32'h4000_0000);
        cycle(0, 0, 0, 0);
        chk("midrst_addr", imem_address, 32'h4000_0000);
        cycle(1, 0, 0, 0);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
